// File: rtl/vx_cache_arb_rr.sv
// vx_cache_arb_rr: N-way request arbiter in front of a single dcache port.
// Requests are granted round-robin or by fixed priority. They pass through a
// two-entry skid buffer with registered outputs. Reads are credit-limited per
// requester. Responses are routed back using select bits held in the tag LSBs.

module vx_cache_arb_rr #(
    parameter int NUM_REQS      = 2,
    parameter int LANES         = 4,
    parameter int DATA_SIZE     = 4,
    parameter int ADDR_WIDTH    = 30,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int ARB_RR        = 1,
    parameter int MAX_PENDING   = 4,
    parameter int SEL_BITS      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQS*LANES-1:0]                 req_valid_in,
    input  logic [NUM_REQS-1:0]                       req_rw_in,
    input  logic [NUM_REQS*LANES*DATA_SIZE-1:0]       req_byteen_in,
    input  logic [NUM_REQS*LANES*ADDR_WIDTH-1:0]      req_addr_in,
    input  logic [NUM_REQS*LANES*DATA_SIZE*8-1:0]     req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]          req_tag_in,
    output logic [NUM_REQS-1:0]                       req_ready_in,
    output logic [LANES-1:0]                          req_valid_out,
    output logic                                      req_rw_out,
    output logic [LANES*DATA_SIZE-1:0]                req_byteen_out,
    output logic [LANES*ADDR_WIDTH-1:0]               req_addr_out,
    output logic [LANES*DATA_SIZE*8-1:0]              req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]                  req_tag_out,
    input  logic                                      req_ready_out,
    input  logic                                      rsp_valid_in,
    input  logic [LANES-1:0]                          rsp_tmask_in,
    input  logic [LANES*DATA_SIZE*8-1:0]              rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]                  rsp_tag_in,
    output logic                                      rsp_ready_in,
    output logic [NUM_REQS-1:0]                       rsp_valid_out,
    output logic [NUM_REQS*LANES-1:0]                 rsp_tmask_out,
    output logic [NUM_REQS*LANES*DATA_SIZE*8-1:0]     rsp_data_out,
    output logic [NUM_REQS*TAG_IN_WIDTH-1:0]          rsp_tag_out,
    input  logic [NUM_REQS-1:0]                       rsp_ready_out
);

    localparam int SEL_W = (SEL_BITS > 0) ? SEL_BITS : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int BE_W  = LANES * DATA_SIZE;
    localparam int AD_W  = LANES * ADDR_WIDTH;
    localparam int DT_W  = LANES * DATA_SIZE * 8;
    localparam int ENT_W = LANES + 1 + BE_W + AD_W + DT_W + TAG_OUT_WIDTH;

    // Arbitration state
    logic [SEL_W-1:0]                 ptr_q, ptr_d;
    logic [NUM_REQS-1:0]              eligible_s;
    logic [NUM_REQS-1:0]              grant_s;
    logic                             grant_found_s;
    logic [SEL_W-1:0]                 grant_idx_s;
    logic                             accept_s;

    // Selected request fields
    logic [LANES-1:0]                 sel_valid_s;
    logic                             sel_rw_s;
    logic [BE_W-1:0]                  sel_byteen_s;
    logic [AD_W-1:0]                  sel_addr_s;
    logic [DT_W-1:0]                  sel_data_s;
    logic [TAG_IN_WIDTH-1:0]          sel_tag_s;
    logic [TAG_OUT_WIDTH-1:0]         new_tag_s;
    logic [ENT_W-1:0]                 new_ent_s;

    // Skid buffer: ent0 is always the head
    logic [ENT_W-1:0]                 ent0_q, ent0_d;
    logic [ENT_W-1:0]                 ent1_q, ent1_d;
    logic [1:0]                       cnt_q, cnt_d;
    logic                             buf_full_s;
    logic                             pop_s;
    logic [LANES-1:0]                 head_valid_s;

    // Outstanding read credits
    logic [NUM_REQS-1:0][CNT_W-1:0]   pend_q, pend_d;
    logic [NUM_REQS-1:0]              pend_inc_s;
    logic [NUM_REQS-1:0]              pend_dec_s;

    // Response routing
    logic [SEL_W-1:0]                 rsp_sel_s;
    logic [NUM_REQS-1:0]              rsp_hit_s;
    logic                             rsp_fire_s;

    // Eligibility: some lane valid, and either a write or a read with a free credit
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible_s[i] = (|req_valid_in[i*LANES +: LANES])
                          && (req_rw_in[i] || (pend_q[i] < CNT_W'(MAX_PENDING)));
        end
    end

    // Grant: RR searches upward from ptr then wraps; fixed picks the lowest index
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        if (ARB_RR != 0) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!grant_found_s && eligible_s[i] && (SEL_W'(i) >= ptr_q)) begin
                    grant_found_s = 1'b1;
                    grant_idx_s   = SEL_W'(i);
                end else begin
                end
            end
        end else begin
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!grant_found_s && eligible_s[i]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = SEL_W'(i);
            end else begin
            end
        end
    end

    // One-hot grant and handshake; nothing is accepted while the buffer is full or in reset
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            grant_s[i] = grant_found_s && (grant_idx_s == SEL_W'(i));
        end
        buf_full_s   = (cnt_q == 2'd2);
        accept_s     = grant_found_s && !buf_full_s && !reset;
        req_ready_in = grant_s & {NUM_REQS{!buf_full_s && !reset}};
    end

    // Mux the granted requester's fields
    always_comb begin
        sel_valid_s  = '0;
        sel_rw_s     = 1'b0;
        sel_byteen_s = '0;
        sel_addr_s   = '0;
        sel_data_s   = '0;
        sel_tag_s    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_s[i]) begin
                sel_valid_s  = req_valid_in[i*LANES +: LANES];
                sel_rw_s     = req_rw_in[i];
                sel_byteen_s = req_byteen_in[i*BE_W +: BE_W];
                sel_addr_s   = req_addr_in[i*AD_W +: AD_W];
                sel_data_s   = req_data_in[i*DT_W +: DT_W];
                sel_tag_s    = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
            end else begin
            end
        end
    end

    // Append the requester index below the tag so responses can find their way home
    generate
        if (SEL_BITS > 0) begin : g_tag_sel
            assign new_tag_s = {sel_tag_s, grant_idx_s};
            assign rsp_sel_s = rsp_tag_in[SEL_BITS-1:0];
        end else begin : g_tag_pass
            assign new_tag_s = sel_tag_s;
            assign rsp_sel_s = '0;
        end
    endgenerate

    assign new_ent_s = {sel_valid_s, sel_rw_s, sel_byteen_s, sel_addr_s, sel_data_s, new_tag_s};

    // Skid buffer next state: push behind the head, pop shifts ent1 forward
    always_comb begin
        pop_s  = (cnt_q != 2'd0) && req_ready_out;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({accept_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = new_ent_s;
                end else begin
                    ent1_d = new_ent_s;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = new_ent_s;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = new_ent_s;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // RR pointer moves past the winner only when a request is actually taken
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s) begin
            if (grant_idx_s == SEL_W'(NUM_REQS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_s + SEL_W'(1);
            end
        end else begin
        end
    end

    // Response routing: decode the select bits, broadcast the payload
    always_comb begin
        rsp_hit_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_hit_s[i] = (rsp_sel_s == SEL_W'(i));
        end
        rsp_ready_in  = |(rsp_hit_s & rsp_ready_out);
        rsp_fire_s    = rsp_valid_in && rsp_ready_in && !reset;
        rsp_valid_out = rsp_hit_s & {NUM_REQS{rsp_valid_in && !reset}};
        rsp_tmask_out = {NUM_REQS{rsp_tmask_in}};
        rsp_data_out  = {NUM_REQS{rsp_data_in}};
        rsp_tag_out   = {NUM_REQS{rsp_tag_in[TAG_OUT_WIDTH-1 -: TAG_IN_WIDTH]}};
    end

    // Credit counters: accepted reads take a credit, delivered responses return one
    always_comb begin
        pend_d     = pend_q;
        pend_inc_s = '0;
        pend_dec_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            pend_inc_s[i] = accept_s && grant_s[i] && !req_rw_in[i];
            pend_dec_s[i] = rsp_fire_s && rsp_hit_s[i];
            case ({pend_inc_s[i], pend_dec_s[i]})
                2'b10:   pend_d[i] = pend_q[i] + CNT_W'(1);
                2'b01:   pend_d[i] = pend_q[i] - CNT_W'(1);
                default: pend_d[i] = pend_q[i];
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            cnt_q  <= 2'd0;
            ent0_q <= '0;
            ent1_q <= '0;
            pend_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            pend_q <= pend_d;
        end
    end

    assign {head_valid_s, req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} = ent0_q;
    assign req_valid_out = (cnt_q != 2'd0) ? head_valid_s : '0;

    vx_cache_arb_rr_chk #(
        .NUM_REQS    (NUM_REQS),
        .SEL_W       (SEL_W),
        .CNT_W       (CNT_W),
        .MAX_PENDING (MAX_PENDING)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .rsp_valid_in (rsp_valid_in),
        .rsp_sel      (rsp_sel_s),
        .pend_inc     (pend_inc_s),
        .pend_dec     (pend_dec_s),
        .pend         (pend_q)
    );

endmodule

// Protocol checks: legal response select and no credit overflow/underflow
module vx_cache_arb_rr_chk #(
    parameter int NUM_REQS    = 2,
    parameter int SEL_W       = 1,
    parameter int CNT_W       = 3,
    parameter int MAX_PENDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rsp_valid_in,
    input  logic [SEL_W-1:0]                 rsp_sel,
    input  logic [NUM_REQS-1:0]              pend_inc,
    input  logic [NUM_REQS-1:0]              pend_dec,
    input  logic [NUM_REQS-1:0][CNT_W-1:0]   pend
);

    a_sel_legal: assert property (@(posedge clk) disable iff (reset)
        rsp_valid_in |-> (int'(rsp_sel) < NUM_REQS));

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_pend
        a_no_ovf: assert property (@(posedge clk) disable iff (reset)
            !(pend_inc[g] && !pend_dec[g] && (pend[g] == CNT_W'(MAX_PENDING))));
        a_no_udf: assert property (@(posedge clk) disable iff (reset)
            !(pend_dec[g] && !pend_inc[g] && (pend[g] == '0)));
    end

endmodule

// File: doc/vx_cache_arb_rr.md
Name: vx_cache_arb_rr

Overview:
- Parametrised N-way arbiter that merges NUM_REQS per-lane cache request streams (LSU, texture unit, further clients) onto one dcache port.
- Routes cache responses back to the issuing requester using select bits appended to the tag.
- Generalises the two-way tex/LSU merge: configurable requester count, round-robin or fixed priority, a registered (skid-buffered) request path, and per-requester outstanding-read credit limiting.

Parameters:
- NUM_REQS, 2, number of requesters (>=1)
- LANES, 4, lanes per request (`NUM_THREADS)
- DATA_SIZE, 4, bytes per lane word
- ADDR_WIDTH, 30, word address width per lane
- TAG_IN_WIDTH, 8, requester tag width
- ARB_RR, 1, 1 = round-robin, 0 = fixed priority (index 0 highest)
- MAX_PENDING, 4, max outstanding reads per requester (>=1)
- SEL_BITS, derived: clog2(NUM_REQS), or 0 when NUM_REQS==1
- TAG_OUT_WIDTH, derived: TAG_IN_WIDTH+SEL_BITS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid_in  in  NUM_REQS*LANES  per-requester lane valid mask
- req_rw_in  in  NUM_REQS  1 = write
- req_byteen_in  in  NUM_REQS*LANES*DATA_SIZE  byte enables
- req_addr_in  in  NUM_REQS*LANES*ADDR_WIDTH  lane addresses
- req_data_in  in  NUM_REQS*LANES*DATA_SIZE*8  write data
- req_tag_in  in  NUM_REQS*TAG_IN_WIDTH  requester tags
- req_ready_in  out  NUM_REQS  per-requester accept
- req_valid_out  out  LANES  lane mask to dcache
- req_rw_out  out  1
- req_byteen_out  out  LANES*DATA_SIZE
- req_addr_out  out  LANES*ADDR_WIDTH
- req_data_out  out  LANES*DATA_SIZE*8
- req_tag_out  out  TAG_OUT_WIDTH  {tag_in, sel}, sel in the LSBs
- req_ready_out  in  1  dcache accept
- rsp_valid_in  in  1  dcache response
- rsp_tmask_in  in  LANES
- rsp_data_in  in  LANES*DATA_SIZE*8
- rsp_tag_in  in  TAG_OUT_WIDTH
- rsp_ready_in  out  1
- rsp_valid_out  out  NUM_REQS
- rsp_tmask_out  out  NUM_REQS*LANES
- rsp_data_out  out  NUM_REQS*LANES*DATA_SIZE*8
- rsp_tag_out  out  NUM_REQS*TAG_IN_WIDTH
- rsp_ready_out  in  NUM_REQS

Behaviour:
- Reset is synchronous. It clears the RR pointer to 0, all pending counters to 0 and the skid buffer to empty. During and after reset: req_valid_out=0, req_ready_in=0 (while reset is high), rsp_valid_out=0.
- Eligibility: requester i is eligible when |req_valid_in[i] is set and (req_rw_in[i]==1 or pending[i]<MAX_PENDING).
- Grant is combinational, one-hot among eligible requesters.
  - RR mode: search starts at ptr. ptr <= grant_idx+1 (mod NUM_REQS) on each accepted request only.
  - Fixed mode: lowest eligible index wins.
- Request path: 2-entry skid buffer.
  - req_ready_in[i] = grant[i] & ~buf_full.
  - Accept = valid & ready. The accepted request appears on the outputs the next cycle (latency 1).
  - Back-to-back throughput of 1/cycle while req_ready_out=1.
  - req_ready_out low: the buffer holds its head stable, absorbs one more request, then deasserts all req_ready_in.
  - Output fields, including lane mask, are held stable while req_valid_out & ~req_ready_out.
- Tag: req_tag_out = {req_tag_in[g], g[SEL_BITS-1:0]}. With NUM_REQS==1 the tag passes through unchanged.
- Response path is combinational, no storage.
  - sel = rsp_tag_in[SEL_BITS-1:0].
  - rsp_valid_out[sel] = rsp_valid_in.
  - tmask, data and tag[TAG_OUT_WIDTH-1:SEL_BITS] are broadcast to all outputs.
  - rsp_ready_in = rsp_ready_out[sel].
  - A sel >= NUM_REQS is illegal; an assertion fires in simulation.
- Pending counters (width clog2(MAX_PENDING+1)):
  - +1 when a read is accepted from requester i.
  - -1 when a response fires to i.
  - Both events in the same cycle: count unchanged.
  - Writes never count. Overflow/underflow is an assertion error.
- A requester at MAX_PENDING with a read is skipped. Other requesters are granted in the same cycle with no bubble.
- Reset mid-operation: buffered requests are dropped and counters cleared. In-flight responses after reset are the environment's responsibility.

Test Plan:
1. NUM_REQS=3, RR, all three requesters continuously valid reads, rsp immediate -> grants in order 0,1,2,0,1,2. req_tag_out LSBs = 0,1,2,... One output request per cycle, first appearing one cycle after the first accept.
2. Fixed priority, requesters 0 and 1 continuously valid -> only 0 is granted. After 0 drops valid, 1 is granted the next cycle.
3. MAX_PENDING=2, requester 0 issues 3 reads with no responses -> third held (ready_in[0]=0) while requester 1's write is accepted. A response with tag LSB=0 frees the credit, and the third read is accepted the following cycle.
4. req_ready_out=0 for 5 cycles with continuous input -> exactly 2 requests accepted, then all req_ready_in=0. Output is stable. On release, both requests drain in order over 2 cycles.
5. rsp_tag_in = {8'hA5, 2'd2}, rsp_ready_out[2]=0 -> rsp_valid_out=3'b100, rsp_tag_out[2]=8'hA5, rsp_ready_in=0, pending[2] unchanged.
6. Assert reset for one cycle with the buffer full and counters nonzero -> next cycle req_valid_out=0, counters 0, RR pointer 0, and the first grant goes to requester 0.
